// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
// State encoding, key map and column drive patterns.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  // Entry {row,col} holds the hex code; row 0 is the top row.
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

  localparam logic [3:0] COL0 = 4'b1110;
  localparam logic [3:0] COL1 = 4'b1101;
  localparam logic [3:0] COL2 = 4'b1011;
  localparam logic [3:0] COL3 = 4'b0111;

  function automatic logic [3:0] key_code(
    input logic [1:0] row,
    input logic [1:0] col
  );
    logic [5:0] idx;
    idx = {row, col, 2'b00};
    return KEYMAP[idx +: 4];
  endfunction

  function automatic logic [3:0] col_drive(
    input logic [1:0] col
  );
    logic [3:0] drv;
    unique case (col)
      2'd0:    drv = COL0;
      2'd1:    drv = COL1;
      2'd2:    drv = COL2;
      default: drv = COL3;
    endcase
    return drv;
  endfunction

endpackage

// File: rtl/keypad_scanner_row_synchronizer.sv
// row_synchronizer: two-flop synchroniser for the keypad row returns.
// Idle rows are pulled high, so reset loads all ones.
module row_synchronizer (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_q;

  // Two-stage capture of the asynchronous rows.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 4'hF;
      q      <= 4'hF;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column scan, debounce and decode of a 4x4 keypad.
// Drives a held key code plus a one-cycle press pulse.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_COUNT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] keypad_value,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_COUNT);

  logic [3:0]    row_sync;
  logic [3:0]    row_low;
  logic          is_single;
  logic [1:0]    hit_row;
  logic          match;
  logic          sample;
  logic [DW-1:0] div_q;

  state_t        state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rel_q, rel_d;
  logic [3:0]    value_q, value_d;
  logic          valid_q, valid_d;
  logic          pressed_q, pressed_d;

  row_synchronizer u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_in),
    .q     (row_sync)
  );

  // Classify the synchronised rows as none, single or multi.
  always_comb begin
    row_low   = ~row_sync;
    is_single = 1'b1;
    hit_row   = 2'd0;
    case (row_low)
      4'b0001: hit_row = 2'd0;
      4'b0010: hit_row = 2'd1;
      4'b0100: hit_row = 2'd2;
      4'b1000: hit_row = 2'd3;
      default: is_single = 1'b0;
    endcase
    match = is_single && (hit_row == cand_q);
  end

  assign sample = (div_q == DIV_LAST);

  // Free-running dwell divider; its last count is the sample cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else if (sample) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Scanner state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SCAN;
      col_q     <= 2'd0;
      cand_q    <= 2'd0;
      cnt_q     <= '0;
      rel_q     <= '0;
      value_q   <= 4'd0;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      rel_q     <= rel_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      pressed_q <= pressed_d;
    end
  end

  // Next-state logic; everything moves only on a sample cycle.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    rel_d     = rel_q;
    value_d   = value_q;
    valid_d   = valid_q;
    pressed_d = 1'b0;
    if (sample) begin
      case (state_q)
        SCAN: begin
          if (is_single) begin
            cand_d  = hit_row;
            cnt_d   = CW'(1);
            state_d = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (match) begin
            if (cnt_q + 1'b1 == CNT_LAST) begin
              value_d   = key_code(cand_q, col_q);
              valid_d   = 1'b1;
              pressed_d = 1'b1;
              cnt_d     = '0;
              rel_d     = '0;
              state_d   = HELD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d   = '0;
            col_d   = col_q + 2'd1;
            state_d = SCAN;
          end
        end
        HELD: begin
          if (match) begin
            rel_d = '0;
          end else if (rel_q + 1'b1 == CNT_LAST) begin
            rel_d   = '0;
            valid_d = 1'b0;
            col_d   = col_q + 2'd1;
            state_d = SCAN;
          end else begin
            rel_d = rel_q + 1'b1;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  assign col_out      = col_drive(col_q);
  assign keypad_value = value_q;
  assign key_valid    = valid_q;
  assign key_pressed  = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized scoreboard bench for keypad_scanner.
// A switch-matrix model drives the rows; a monitor checks press pulses.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] keypad_value;
  logic       key_valid;
  logic       key_pressed;

  logic [15:0] keys = '0;
  logic [3:0]  exp_q[$];
  int tests = 0;
  int fails = 0;
  int press_cnt = 0;
  logic prev_p = 1'b0;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_COUNT (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .row_in       (row_in),
    .col_out      (col_out),
    .keypad_value (keypad_value),
    .key_valid    (key_valid),
    .key_pressed  (key_pressed)
  );

  always #5 clk = ~clk;

  // Switch matrix: a closed key shorts its row to a driven-low column.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  function automatic logic [3:0] code_of(input int r, input int c);
    string lay;
    byte ch;
    lay = "123A456B789CE0FD";
    ch = lay[r*4+c];
    if (ch >= "0" && ch <= "9") return 4'(ch - "0");
    return 4'(ch - "A" + 10);
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_press(input int bound, output int lat);
    int start;
    start = press_cnt;
    lat = 0;
    while (press_cnt == start && lat < bound) begin
      step();
      lat++;
    end
    check("press_seen", 32'(press_cnt != start), 1);
  endtask

  task automatic wait_release(input int bound, output int lat);
    lat = 0;
    while (key_valid && lat < bound) begin
      step();
      lat++;
    end
    check("release_seen", 32'(key_valid), 0);
  endtask

  task automatic wait_frozen(input logic [3:0] target, input int bound);
    int run;
    int n;
    run = 0;
    n = 0;
    while (run < 5 && n < bound) begin
      if (col_out == target) run++;
      else run = 0;
      if (run < 5) begin
        step();
        n++;
      end
    end
    check("column_frozen", 32'(run), 5);
  endtask

  // Monitor: every press pulse must match the oldest expected code.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && key_pressed) begin
        press_cnt++;
        check("pulse_gap", 32'(prev_p), 0);
        check("valid_with_pulse", 32'(key_valid), 1);
        check("press_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0)
          check("press_code", 32'(keypad_value), 32'(exp_q.pop_front()));
      end
      prev_p = key_pressed;
    end
  end

  // Stimulus sequence.
  initial begin
    int lat;
    int start;
    int n;
    int r;
    int c;
    logic ok;
    logic saw_low;
    logic [3:0] exp_col;

    repeat (3) step();
    check("rst_col", 32'(col_out), 32'(4'b1110));
    check("rst_value", 32'(keypad_value), 0);
    check("rst_valid", 32'(key_valid), 0);
    check("rst_pressed", 32'(key_pressed), 0);

    reset = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_col = ~(4'b0001 << ((i / 4) % 4));
      if (col_out !== exp_col) ok = 1'b0;
      step();
    end
    check("idle_rotation", 32'(ok), 1);

    keys[1*4+2] = 1'b1;
    exp_q.push_back(code_of(1, 2));
    wait_press(40, lat);
    check("press6_latency", 32'(lat <= 27), 1);
    check("press6_valid", 32'(key_valid), 1);
    ok = 1'b1;
    repeat (200) begin
      step();
      if (col_out !== 4'b1011) ok = 1'b0;
    end
    check("press6_frozen", 32'(ok), 1);
    check("press6_held_value", 32'(keypad_value), 6);

    keys = '0;
    wait_release(20, lat);
    check("release6_latency", 32'(lat <= 13), 1);
    check("release6_value", 32'(keypad_value), 6);
    check("release6_next_col", 32'(col_out), 32'(4'b0111));

    keys[3*4+0] = 1'b1;
    wait_frozen(4'b1110, 40);
    keys = '0;
    repeat (4) step();
    check("bounce_no_valid", 32'(key_valid), 0);
    check("bounce_resume_col", 32'(col_out), 32'(4'b1101));
    exp_q.push_back(code_of(3, 0));
    keys[3*4+0] = 1'b1;
    wait_press(40, lat);
    check("bounce_value", 32'(keypad_value), 14);
    keys = '0;
    wait_release(20, lat);

    keys[0] = 1'b1;
    exp_q.push_back(code_of(0, 0));
    wait_press(40, lat);
    keys[2*4+3] = 1'b1;
    repeat (60) step();
    check("rollover_value", 32'(keypad_value), 1);
    check("rollover_valid", 32'(key_valid), 1);
    keys[0] = 1'b0;
    exp_q.push_back(code_of(2, 3));
    start = press_cnt;
    saw_low = 1'b0;
    n = 0;
    while (press_cnt == start && n < 80) begin
      if (!key_valid) saw_low = 1'b1;
      step();
      n++;
    end
    check("rollover_dropped", 32'(saw_low), 1);
    check("rollover_second", 32'(press_cnt != start), 1);
    check("rollover_code", 32'(keypad_value), 12);
    keys = '0;
    wait_release(20, lat);

    for (int k = 0; k < 8; k++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      exp_q.push_back(code_of(r, c));
      keys[r*4+c] = 1'b1;
      wait_press(40, lat);
      check("rand_latency", 32'(lat <= 27), 1);
      repeat ($urandom_range(0, 20)) step();
      keys = '0;
      wait_release(20, lat);
      check("rand_value_kept", 32'(keypad_value), 32'(code_of(r, c)));
      repeat ($urandom_range(4, 12)) step();
    end

    keys[1*4+2] = 1'b1;
    wait_frozen(4'b1011, 60);
    reset = 1'b1;
    keys = '0;
    step();
    step();
    check("mid_rst_col", 32'(col_out), 32'(4'b1110));
    check("mid_rst_value", 32'(keypad_value), 0);
    check("mid_rst_valid", 32'(key_valid), 0);
    check("mid_rst_pressed", 32'(key_pressed), 0);
    reset = 1'b0;
    repeat (40) step();
    check("no_pending_presses", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
